// File: rtl/spi_oled_pkg.sv
// rtl/spi_oled_pkg.sv - shared types and constants for the OLED SPI burst transmitter
package spi_oled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;

    // Width of an index/counter covering 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_oled_burst_tx_if.sv
// rtl/spi_oled_burst_tx_if.sv - request/handshake bundle between sequencer and burst transmitter
interface spi_oled_burst_tx_if
    import spi_oled_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 8
);
    logic [N*WIDTH-1:0]        i_DATA;
    logic [N-1:0]              i_DC;
    logic [$clog2(N+1)-1:0]    i_N_transmit;
    logic                      i_CS_HOLD;
    logic                      i_START;
    logic                      o_BUSY;
    logic                      o_BYTE_DONE;
    logic [idx_width(N)-1:0]   o_BYTE_IDX;
    logic                      o_DONE;

    modport master (
        output i_DATA, i_DC, i_N_transmit, i_CS_HOLD, i_START,
        input  o_BUSY, o_BYTE_DONE, o_BYTE_IDX, o_DONE
    );

    modport slave (
        input  i_DATA, i_DC, i_N_transmit, i_CS_HOLD, i_START,
        output o_BUSY, o_BYTE_DONE, o_BYTE_IDX, o_DONE
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with leading/trailing edge strobes, idles at CPOL
module spi_sclk_gen
    import spi_oled_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter bit CPOL    = 1'b0
) (
    input  logic i_SCK,
    input  logic i_RST,
    input  logic i_EN,
    output logic o_SCLK,
    output logic o_LEAD,
    output logic o_TRAIL
);
    localparam int CW = idx_width(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    // The register edge that ends a half-period is where SCLK toggles
    assign tick    = i_EN && (cnt_q == DIV_LAST);
    assign o_SCLK  = sclk_q;
    assign o_LEAD  = tick && !phase_q;
    assign o_TRAIL = tick && phase_q;

    // Divider next state: restart from idle whenever disabled
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        sclk_d  = sclk_q;
        if (!i_EN) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            sclk_d  = CPOL;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            sclk_d  = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider registers
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= CPOL;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end
endmodule

// File: rtl/spi_oled_burst_tx.sv
// rtl/spi_oled_burst_tx.sv - N-word SPI MOSI burst transmitter with per-word D/C and CS framing
module spi_oled_burst_tx
    import spi_oled_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N         = 8,
    parameter int CLK_DIV   = 2,
    parameter bit CPOL      = 1'b0,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CS_GAP    = 2
) (
    input  logic                i_SCK,
    input  logic                i_RST,
    spi_oled_burst_tx_if.slave  bus,
    output logic                o_SCLK,
    output logic                o_MOSI,
    output logic                o_CS,
    output logic                o_DC
);
    localparam int CNTW = $clog2(N + 1);
    localparam int IW   = idx_width(N);
    localparam int BW   = idx_width(WIDTH);
    localparam int GW   = idx_width(CS_GAP);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    state_e               state_q, state_d;
    logic [N*WIDTH-1:0]   data_q, data_d;
    logic [N-1:0]         dcs_q, dcs_d;
    logic                 hold_q, hold_d;
    logic [CNTW-1:0]      left_q, left_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_q, cs_d;
    logic                 dc_q, dc_d;
    logic                 busy_q, busy_d;
    logic                 bdone_q, bdone_d;
    logic                 done_q, done_d;

    logic [CNTW-1:0]      count;
    logic [IW-1:0]        nidx;
    logic [WIDTH-1:0]     next_word;
    logic [WIDTH-1:0]     shifted;
    logic                 load_next;
    logic                 sclk_trail;
    logic                 sclk_lead_unused;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_sclk (
        .i_SCK   (i_SCK),
        .i_RST   (i_RST),
        .i_EN    (state_q == ST_SHIFT),
        .o_SCLK  (o_SCLK),
        .o_LEAD  (sclk_lead_unused),
        .o_TRAIL (sclk_trail)
    );

    assign count     = (bus.i_N_transmit > CNTW'(N)) ? CNTW'(N) : bus.i_N_transmit;
    assign nidx      = idx_q + 1'b1;
    assign next_word = data_q[int'(nidx)*WIDTH +: WIDTH];
    assign shifted   = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);

    // Frame/shift FSM: next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dcs_d     = dcs_q;
        hold_d    = hold_q;
        left_d    = left_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        dc_d      = dc_q;
        busy_d    = busy_q;
        bdone_d   = 1'b0;
        done_d    = 1'b0;
        load_next = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (bus.i_START) begin
                    data_d = bus.i_DATA;
                    dcs_d  = bus.i_DC;
                    hold_d = bus.i_CS_HOLD;
                    if (count == '0) begin
                        // Empty burst: report completion without touching CS
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        left_d  = count - 1'b1;
                        sh_d    = bus.i_DATA[WIDTH-1:0];
                        mosi_d  = first_bit(bus.i_DATA[WIDTH-1:0]);
                        dc_d    = bus.i_DC[0];
                        bit_d   = '0;
                        cs_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (sclk_trail) begin
                    if (bit_q == BIT_LAST) begin
                        bdone_d = 1'b1;
                        if (left_q == '0) begin
                            state_d = ST_FINISH;
                            cs_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (hold_q) begin
                            load_next = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            cs_d    = 1'b1;
                            gap_d   = '0;
                        end
                    end else begin
                        // Advance MOSI only on trailing edges so it is stable at the sampling edge
                        bit_d  = bit_q + 1'b1;
                        sh_d   = shifted;
                        mosi_d = first_bit(shifted);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d   = ST_SHIFT;
                    cs_d      = 1'b0;
                    load_next = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Present the following word; D/C changes only here, with SCLK at idle
        if (load_next) begin
            idx_d  = nidx;
            sh_d   = next_word;
            mosi_d = first_bit(next_word);
            dc_d   = dcs_q[nidx];
            bit_d  = '0;
            left_d = left_q - 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dcs_q   <= '0;
            hold_q  <= 1'b0;
            left_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= OLED_DC_CMD;
            busy_q  <= 1'b0;
            bdone_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dcs_q   <= dcs_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            busy_q  <= busy_d;
            bdone_q <= bdone_d;
            done_q  <= done_d;
        end
    end

    assign o_MOSI          = mosi_q;
    assign o_CS            = cs_q;
    assign o_DC            = dc_q;
    assign bus.o_BUSY      = busy_q;
    assign bus.o_BYTE_DONE = bdone_q;
    assign bus.o_BYTE_IDX  = idx_q;
    assign bus.o_DONE      = done_q;
endmodule

// File: tb/tb_spi_oled_burst_tx.sv
// tb/tb_spi_oled_burst_tx.sv - scoreboard bench for spi_oled_burst_tx
module tb_spi_oled_burst_tx;
    localparam int W  = 8;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_oled_burst_tx_if #(.WIDTH(W), .N(NW)) if0 ();
    spi_oled_burst_tx_if #(.WIDTH(W), .N(NW)) if1 ();

    logic [31:0] data   = '0;
    logic [3:0]  dcv    = '0;
    logic [2:0]  ntx    = '0;
    logic        hold   = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;

    assign if0.i_DATA = data;  assign if1.i_DATA = data;
    assign if0.i_DC = dcv;     assign if1.i_DC = dcv;
    assign if0.i_N_transmit = ntx; assign if1.i_N_transmit = ntx;
    assign if0.i_CS_HOLD = hold;   assign if1.i_CS_HOLD = hold;
    assign if0.i_START = start0;   assign if1.i_START = start1;

    logic sclk0, mosi0, cs0, dc0;
    logic sclk1, mosi1, cs1, dc1;

    spi_oled_burst_tx #(.WIDTH(W), .N(NW), .CLK_DIV(2), .CPOL(1'b0), .LSB_FIRST(1'b0), .CS_GAP(2)) dut0 (
        .i_SCK(clk), .i_RST(rst), .bus(if0),
        .o_SCLK(sclk0), .o_MOSI(mosi0), .o_CS(cs0), .o_DC(dc0)
    );

    spi_oled_burst_tx #(.WIDTH(W), .N(NW), .CLK_DIV(2), .CPOL(1'b1), .LSB_FIRST(1'b1), .CS_GAP(2)) dut1 (
        .i_SCK(clk), .i_RST(rst), .bus(if1),
        .o_SCLK(sclk1), .o_MOSI(mosi1), .o_CS(cs1), .o_DC(dc1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor follows one DUT at a time; sel also equals that DUT's CPOL and LSB_FIRST
    bit sel = 1'b0;
    logic m_sclk, m_mosi, m_cs, m_dc, m_busy, m_bd, m_done;
    logic [1:0] m_idx;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_cs   = sel ? cs1 : cs0;
    assign m_dc   = sel ? dc1 : dc0;
    assign m_busy = sel ? if1.o_BUSY : if0.o_BUSY;
    assign m_bd   = sel ? if1.o_BYTE_DONE : if0.o_BYTE_DONE;
    assign m_done = sel ? if1.o_DONE : if0.o_DONE;
    assign m_idx  = sel ? if1.o_BYTE_IDX : if0.o_BYTE_IDX;

    logic [10:0] exp_q[$];
    int   cyc = 0, cs_low = 0, cs_hi_busy = 0, bd_cnt = 0, done_cnt = 0, done_cyc = 0, bitn = 0;
    logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_cs_at_done = 1'b1;
    logic dc_first = 1'b0, dc_bad = 1'b0;
    logic [1:0] idx_first = '0;
    logic [7:0] w = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (!m_cs) cs_low++;
            if (m_cs && m_busy) cs_hi_busy++;
            if (m_bd) bd_cnt++;
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
                prev_cs_at_done = prev_cs;
            end
            if (m_cs) begin
                bitn = 0;
            end else if (prev_sclk == sel && m_sclk != sel) begin
                if (bitn == 0) begin
                    dc_first  = m_dc;
                    idx_first = m_idx;
                end else if (m_dc !== dc_first) begin
                    dc_bad = 1'b1;
                end
                w = sel ? {m_mosi, w[7:1]} : {w[6:0], m_mosi};
                bitn++;
                if (bitn == W) begin
                    bitn = 0;
                    if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
                    else chk("word", {21'b0, idx_first, dc_first, w}, {21'b0, exp_q.pop_front()});
                end
            end
        end
        prev_sclk = m_sclk;
        prev_cs   = m_cs;
    end

    task automatic run(input string name, input bit s, input logic [31:0] d, input logic [3:0] dc,
                       input logic [2:0] n, input logic h, input bit poke);
        int words, gapc, st, i;
        words = (n > 3'd4) ? 4 : int'(n);
        gapc  = (h || words == 0) ? 0 : 2 * (words - 1);
        sel = s;
        @(posedge clk); #1;
        data = d; dcv = dc; ntx = n; hold = h;
        cs_low = 0; cs_hi_busy = 0; bd_cnt = 0; done_cnt = 0; done_cyc = 0; dc_bad = 1'b0;
        for (int k = 0; k < words; k++) exp_q.push_back({k[1:0], dc[k], d[8*k +: 8]});
        if (s) start1 = 1'b1; else start0 = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        i = 0;
        while (done_cnt == 0 && i < 1000) begin
            @(posedge clk); #1;
            i++;
            if (poke && i == 10) begin
                data = ~d; dcv = ~dc; ntx = 3'd1; hold = ~h;
                if (s) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0; start1 = 1'b0;
            end
        end
        chk({name, "_timeout"}, 32'(i >= 1000), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_latency"}, done_cyc - st, 2 + 32 * words + gapc);
        chk({name, "_cs_low"}, cs_low, 32 * words);
        chk({name, "_cs_gap"}, cs_hi_busy, gapc);
        chk({name, "_byte_done"}, bd_cnt, words);
        chk({name, "_dc_stable"}, {31'b0, dc_bad}, 32'd0);
        chk({name, "_words_left"}, exp_q.size(), 0);
        chk({name, "_cs_before_done"}, {31'b0, prev_cs_at_done}, (words > 0) ? 32'd0 : 32'd1);
        chk({name, "_idle_busy"}, {31'b0, m_busy}, 32'd0);
        chk({name, "_idle_idx"}, {30'b0, m_idx}, 32'd0);
        chk({name, "_idle_sclk"}, {31'b0, m_sclk}, {31'b0, sel});
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_sclk"}, {31'b0, sclk0}, 32'd0);
        chk({name, "_mosi"}, {31'b0, mosi0}, 32'd0);
        chk({name, "_cs"}, {31'b0, cs0}, 32'd1);
        chk({name, "_dc"}, {31'b0, dc0}, 32'd0);
        chk({name, "_busy"}, {31'b0, if0.o_BUSY}, 32'd0);
        chk({name, "_bdone"}, {31'b0, if0.o_BYTE_DONE}, 32'd0);
        chk({name, "_idx"}, {30'b0, if0.o_BYTE_IDX}, 32'd0);
        chk({name, "_done"}, {31'b0, if0.o_DONE}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        chk("rst0_sclk_cpol1", {31'b0, sclk1}, 32'd1);
        chk("rst0_cs1", {31'b0, cs1}, 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run("single", 1'b0, 32'h0000_00A5, 4'b0000, 3'd1, 1'b1, 1'b0);
        run("hold",   1'b0, 32'h0000_3CAE, 4'b0010, 3'd2, 1'b1, 1'b0);
        run("gap",    1'b0, 32'h0000_3CAE, 4'b0010, 3'd2, 1'b0, 1'b0);
        run("empty",  1'b0, 32'h1234_5678, 4'b1111, 3'd0, 1'b0, 1'b0);
        run("clamp",  1'b0, 32'h81C3_5A0F, 4'b1010, 3'd7, 1'b1, 1'b0);
        run("clampg", 1'b0, 32'h6699_F00D, 4'b0101, 3'd7, 1'b0, 1'b0);
        run("lsbcp1", 1'b1, 32'h0000_0001, 4'b0001, 3'd1, 1'b1, 1'b0);
        run("poke",   1'b0, 32'h0000_C35A, 4'b0001, 3'd2, 1'b1, 1'b1);

        // Reset in the middle of a word with MOSI and D/C driven high
        sel = 1'b0;
        @(posedge clk); #1;
        data = 32'h0000_FFFF; dcv = 4'b1111; ntx = 3'd2; hold = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_pre_cs", {31'b0, cs0}, 32'd0);
        chk("midrst_pre_dc", {31'b0, dc0}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);

        run("recover", 1'b0, 32'h0000_00A5, 4'b0001, 3'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_oled_burst_tx.md
Name: spi_oled_burst_tx

Overview:
- Parametrised N-byte SPI MOSI burst transmitter for the OLED interface.
- Latches up to N words of WIDTH bits, each with its own D/C flag, on one start request. Shifts them out MSB- or LSB-first with an internally divided SCLK of selectable polarity.
- Per-call choice: hold CS low across the whole burst, or toggle CS between words.
- Sits between the OLED init/draw sequencer and the display pins. Generalises the fixed 8x8 buffer plus shifter pair with clock generation, framing mode, and a busy/done handshake.

Parameters:
- WIDTH, 8, bits per word.
- N, 8, maximum words per burst.
- CLK_DIV, 2, i_SCK cycles per SCLK half-period (>=1).
- CPOL, 0, SCLK idle level. Data is always sampled by the slave on the first SCLK edge after CS low (CPHA=0).
- LSB_FIRST, 0, 1 = shift bit 0 first.
- CS_GAP, 2, i_SCK cycles CS held high between words when not in hold mode (>=1).

Ports:
- i_SCK  in  1  system clock; all logic on rising edge.
- i_RST  in  1  synchronous active-high reset.
- i_DATA  in  N*WIDTH  word k = i_DATA[(k+1)*WIDTH-1 : k*WIDTH]; word 0 is sent first.
- i_DC  in  N  D/C flag for word k (0 = command, 1 = data).
- i_N_transmit  in  $clog2(N+1)  number of words in the burst.
- i_CS_HOLD  in  1  1 = CS low for the whole burst; 0 = CS pulses high CS_GAP cycles between words.
- i_START  in  1  request; accepted only when o_BUSY=0.
- o_SCLK  out  1  SPI clock.
- o_MOSI  out  1  serial data.
- o_CS  out  1  chip select, active low.
- o_DC  out  1  D/C of the word currently shifting.
- o_BUSY  out  1  high from the cycle after acceptance until o_DONE.
- o_BYTE_DONE  out  1  one-cycle pulse after each word's last SCLK trailing edge.
- o_BYTE_IDX  out  $clog2(N)  index of the word being shifted.
- o_DONE  out  1  one-cycle pulse at burst end.

Behaviour:
- Reset values (next edge with i_RST=1, from any state, including mid-burst): o_SCLK=CPOL, o_MOSI=0, o_CS=1, o_DC=0, o_BUSY=0, o_BYTE_DONE=0, o_BYTE_IDX=0, o_DONE=0. All counters cleared; state IDLE.
- FSM states: IDLE, SHIFT, GAP, FINISH.
- IDLE + i_START at edge t:
  - Latch i_DATA, i_DC, i_CS_HOLD.
  - Count = min(i_N_transmit, N).
  - If count=0: go to FINISH; CS is never asserted.
  - Otherwise go to SHIFT. At t+1: o_CS=0, o_BUSY=1, o_DC=flag0, o_MOSI=first bit of word 0.
- SHIFT:
  - Divider counts 0..CLK_DIV-1.
  - First SCLK toggle (leading edge) at t+1+CLK_DIV. Toggles continue every CLK_DIV cycles.
  - MOSI advances to the next bit on each trailing edge, except after the last bit.
  - One word = 2*WIDTH*CLK_DIV cycles.
  - After the last trailing edge: o_BYTE_DONE pulses, SCLK is back at CPOL.
    - More words, hold mode: next word's first bit and D/C are presented in the same cycle; remain in SHIFT.
    - More words, gap mode: o_CS=1 for CS_GAP cycles (GAP state), then CS=0 with the next word loaded.
    - Last word: go to FINISH.
- FINISH (one cycle): o_CS=1, o_DONE=1. o_BUSY drops in the same cycle. Next cycle: IDLE.
- i_START while busy is ignored; no queueing. i_START in the o_DONE cycle is ignored; accepted from the following cycle.
- Input changes after acceptance have no effect on the burst in flight.
- o_BYTE_IDX increments as each new word is loaded; returns to 0 in IDLE.
- i_N_transmit > N is clamped to N without error.
- o_DC is stable for the whole word and never changes while CS=0 within a word.

Decomposition:
- Package spi_oled_pkg holds:
  - FSM state encoding;
  - OLED_DC_CMD=0, OLED_DC_DATA=1;
  - index-width helper constants.
- One natural sub-module, spi_sclk_gen: divider plus edge strobes (lead/trail), enable input, idles at CPOL. The shift/frame FSM stays in the top module.

Test Plan:
- WIDTH=8, N=4, CLK_DIV=2, CPOL=0, MSB-first, single word: i_DATA word0=0xA5, i_DC=0, N_transmit=1 -> CS low 32 cycles; MOSI at rising edges 1,0,1,0,0,1,0,1; DC=0; one BYTE_DONE; DONE 1 cycle after the last falling edge.
- Burst, hold mode: words 0xAE (cmd), 0x3C (data), N_transmit=2, i_CS_HOLD=1 -> CS continuously low 64 cycles; DC 0 then 1, switching while SCLK low; BYTE_IDX 0->1; two BYTE_DONE pulses.
- Same burst, i_CS_HOLD=0 -> CS high exactly CS_GAP=2 cycles between words; each word framed by its own CS.
- N_transmit=0 and N_transmit=7 -> first: DONE next cycle, CS never low; second: exactly 4 words sent (clamped).
- LSB_FIRST=1, CPOL=1, word 0x01 -> SCLK idles high; first sampled bit 1, remaining 0s.
- i_RST asserted mid-word, and i_START pulsed while busy -> reset: all outputs at reset values next edge. START while busy: no effect on bit stream or word count.
